// File: rtl/ads1675_pkg.sv
// Shared types and defaults for the ADS1675 serial deserializer.
// The error counter is only present when ADS1675_DESER_ERRCNT_EN is defined.
package ads1675_pkg;

  localparam int DEF_DW   = 24;
  localparam int ERRCNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Raw ADC line set, kept together so all three see the same sync delay
  typedef struct packed {
    logic sclk;
    logic drdy;
    logic dout;
  } ser_t;

endpackage

// File: rtl/ads1675_sync_edge.sv
// Multi-flop synchronizer for a bundle of async lines, plus per-line
// falling-edge detect on the synchronized outputs.
module ads1675_sync_edge #(
  parameter int W      = 3,
  parameter int STAGES = 2
)(
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dsync,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] pipe;
  logic [W-1:0]             last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pipe <= '0;
      last <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      last <= pipe[STAGES-1];
    end
  end

  assign dsync = pipe[STAGES-1];
  assign fall  = last & ~dsync;

endmodule

// File: rtl/ads1675_deser.sv
// ADS1675 serial-to-parallel receiver with valid/ready output.
// Define ADS1675_DESER_ERRCNT_EN to add the saturating err_cnt output.
module ads1675_deser
  import ads1675_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int SYNC_STAGES = 2
)(
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          en,
  input  logic          sclk,
  input  logic          drdy,
  input  logic          dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          frame_err,
  output logic          overflow,
  output logic          busy
`ifdef ADS1675_DESER_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int CW = $clog2(DW) + 1;

  ser_t lines_raw, lines_s, lines_fall;

  assign lines_raw = {sclk, drdy, dout};

  ads1675_sync_edge #(
    .W      ($bits(ser_t)),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (lines_raw),
    .dsync   (lines_s),
    .fall    (lines_fall)
  );

  logic unused_fall;
  assign unused_fall = &{1'b0, lines_fall.drdy, lines_fall.dout};

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic [DW-1:0] word;
  logic          drdy_prev;
  logic          strobe, start, last_bit;

  assign strobe   = lines_fall.sclk;
  assign start    = en && strobe && lines_s.drdy && !drdy_prev;
  assign last_bit = en && strobe && !start && (state == SHIFT) && (bit_cnt == CW'(DW-1));
  assign word     = {shreg[DW-2:0], lines_s.dout};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      // Treated as "high" so a drdy still asserted at release is not a frame start
      drdy_prev <= 1'b1;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (strobe) drdy_prev <= lines_s.drdy;

      if (!en) begin
        state   <= IDLE;
        busy    <= 1'b0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (start) begin
        // A start seen mid-frame abandons the partial word and restarts here
        state     <= SHIFT;
        busy      <= 1'b1;
        bit_cnt   <= CW'(1);
        shreg     <= {{(DW-1){1'b0}}, lines_s.dout};
        frame_err <= (state == SHIFT);
      end else if (strobe && state == SHIFT) begin
        if (last_bit) begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
          shreg   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= word;
        end
      end

      if (last_bit) begin
        if (!m_valid || m_ready) begin
          m_data  <= word;
          m_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef ADS1675_DESER_ERRCNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      err_cnt <= '0;
    else if ((frame_err || overflow) && (err_cnt != '1))
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule
